// File: rtl/pool2x2_engine.sv
// pool2x2_engine
// 2x2 / stride-2 signed max-pooling layer engine. On a start pulse it reads
// an IN_DIM x IN_DIM feature map through a synchronous read port (data one
// cycle after rd_en). It writes the OUT_DIM x OUT_DIM pooled maxima through a
// write port, then holds done until the next accepted start.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   begin a pass (sampled in IDLE or DONE only)
//   busy     out  pass in progress
//   done     out  level, pass complete
//   rd_en    out  read request to input buffer
//   rd_addr  out  input address, row-major
//   rd_data  in   input data, valid one cycle after rd_en
//   wr_en    out  write strobe, one cycle per pooled result
//   wr_addr  out  output address, row-major
//   wr_data  out  pooled maximum (bit-exact copy of one input element)

module pool2x2_engine #(
    parameter int DATA_W = 32,
    parameter int IN_DIM = 6,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CNT_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(OUT_DIM - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IN_DIM);
    localparam logic [ADDR_W-1:0] WIN_ROW  = ADDR_W'(2 * IN_DIM);
    localparam logic [ADDR_W-1:0] OUT_STEP = ADDR_W'(OUT_DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_R0,
        S_R1,
        S_R2,
        S_R3,
        S_CMP,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  orow_q, orow_d;
    logic [CNT_W-1:0]  ocol_q, ocol_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [ADDR_W-1:0] base;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Next-state and window counters
    always_comb begin
        state_d = state_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_R0;
                    orow_d  = '0;
                    ocol_d  = '0;
                end
            end
            S_R0:  state_d = S_R1;
            S_R1:  state_d = S_R2;
            S_R2:  state_d = S_R3;
            S_R3:  state_d = S_CMP;
            S_CMP: state_d = S_WR;
            S_WR: begin
                if (ocol_q == LAST_IDX) begin
                    if (orow_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        ocol_d  = '0;
                        orow_d  = orow_q + CNT_W'(1);
                        state_d = S_R0;
                    end
                end else begin
                    ocol_d  = ocol_q + CNT_W'(1);
                    state_d = S_R0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the *next* state and
    // next counters; this puts R0's read in the cycle right after start.
    always_comb begin
        base      = (ADDR_W'(orow_d) * WIN_ROW) + (ADDR_W'(ocol_d) << 1);
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        rd_en_d   = (state_d == S_R0) || (state_d == S_R1) ||
                    (state_d == S_R2) || (state_d == S_R3);
        rd_addr_d = rd_addr_q;
        unique case (state_d)
            S_R0:    rd_addr_d = base;
            S_R1:    rd_addr_d = base + ADDR_W'(1);
            S_R2:    rd_addr_d = base + ROW_STEP;
            S_R3:    rd_addr_d = base + ROW_STEP + ADDR_W'(1);
            default: rd_addr_d = rd_addr_q;
        endcase

        // Read data arrives one cycle after each read: R1..CMP. The first
        // sample loads unconditionally; later ones replace only if strictly
        // greater, so ties keep the earlier element.
        max_d = max_q;
        unique case (state_q)
            S_R1: max_d = rd_data;
            S_R2, S_R3, S_CMP: begin
                if ($signed(rd_data) > $signed(max_q)) begin
                    max_d = rd_data;
                end
            end
            default: max_d = max_q;
        endcase

        wr_en_d   = (state_d == S_WR);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == S_WR) begin
            wr_addr_d = (ADDR_W'(orow_q) * OUT_STEP) + ADDR_W'(ocol_q);
            wr_data_d = max_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            orow_q    <= '0;
            ocol_q    <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            max_q     <= max_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_pool2x2_engine.sv
// Testbench for pool2x2_engine: synchronous-read memory model, scoreboard of
// expected writes checked by an independent monitor, per-cycle protocol checks.

module tb_pool2x2_engine;

    localparam int DATA_W = 32;
    localparam int IN_DIM = 6;
    localparam int ADDR_W = 6;
    localparam int NWIN   = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    always #5 clk = ~clk;

    pool2x2_engine #(
        .DATA_W(DATA_W),
        .IN_DIM(IN_DIM),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    // Input buffer: data appears exactly one cycle after rd_en
    logic [DATA_W-1:0] mem [0:63];
    initial rd_data = '0;
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total  = 0;
    int  bad    = 0;
    int  wr_cnt = 0;
    int  cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_wr cyc=%0d actual_addr=%0d actual_data=%0h expected=none",
                         cyc, wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.a));
                chk("wr_data", 64'(wr_data), 64'(e.d));
            end
        end
    end

    task automatic push_exp(input int v[NWIN]);
        for (int i = 0; i < NWIN; i++) begin
            wr_t e;
            e.a = ADDR_W'(i);
            e.d = DATA_W'(v[i]);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle 0).
    // Walks cycles 1..60 and returns at the negedge of cycle 60.
    task automatic run_pass(input int ign_cyc, input int v[NWIN]);
        int w0;
        int off[4];
        int w4[4];
        off = '{0, 1, IN_DIM, IN_DIM + 1};
        w4  = '{14, 15, 20, 21};
        push_exp(v);
        w0    = wr_cnt;
        cyc   = 0;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            int k;
            int w;
            int base;
            logic rd_exp;
            @(negedge clk);
            cyc    = c;
            k      = (c - 1) % 6;
            w      = (c - 1) / 6;
            base   = 2 * (w / 3) * IN_DIM + 2 * (w % 3);
            rd_exp = (c <= 54) && (k < 4);
            chk("busy",  64'(busy),  64'(c <= 54));
            chk("done",  64'(done),  64'(c >= 55));
            chk("rd_en", 64'(rd_en), 64'(rd_exp));
            chk("wr_en", 64'(wr_en), 64'((c <= 54) && (k == 5)));
            if (rd_exp) chk("rd_addr", 64'(rd_addr), 64'(base + off[k]));
            if (c >= 25 && c <= 28) chk("win4_rd_addr", 64'(rd_addr), 64'(w4[c - 25]));
            start = (c == ign_cyc);
        end
        chk("wr_pulses", 64'(wr_cnt - w0), 64'(NWIN));
        chk("sb_drain", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    64'(busy),    64'(0));
        chk({tag, "_done"},    64'(done),    64'(0));
        chk({tag, "_rd_en"},   64'(rd_en),   64'(0));
        chk({tag, "_wr_en"},   64'(wr_en),   64'(0));
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(0));
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
        chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    endtask

    int exp_ramp[NWIN] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int exp_neg[NWIN]  = '{-1, -3, -5, -13, -15, -17, -25, -27, -29};
    int exp_ties[NWIN] = '{5, 32'h7FFFFFFF, -1, 19, 21, 23, 31, 33, 35};

    task automatic load_ramp();
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        rst   = 1'b1;
        start = 1'b0;
        load_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp with an ignored start mid-pass, then restart from DONE at cycle 60
        run_pass(10, exp_ramp);
        run_pass(-1, exp_ramp);

        // All-negative map
        for (int i = 0; i < 64; i++) mem[i] = DATA_W'(-(i + 1));
        run_pass(-1, exp_neg);

        // Ties, max in last slot, most-negative value
        load_ramp();
        mem[0]  = 32'd5;        mem[1]  = 32'd5;
        mem[6]  = 32'd5;        mem[7]  = 32'd5;
        mem[2]  = 32'd0;        mem[3]  = 32'd0;
        mem[8]  = 32'd0;        mem[9]  = 32'h7FFFFFFF;
        mem[4]  = 32'h80000000; mem[5]  = 32'hFFFFFFFF;
        mem[10] = 32'hFFFFFFFE; mem[11] = 32'hFFFFFFFD;
        run_pass(-1, exp_ties);

        // Reset mid-pass at cycle 20
        load_ramp();
        push_exp(exp_ramp);
        w0    = wr_cnt;
        cyc   = 0;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            cyc   = c;
            start = 1'b0;
            if (c >= 21) chk_all_zero("midrst");
            if (c == 20) rst = 1'b1;
            if (c == 21) begin
                rst = 1'b0;
                exp_q.delete();
            end
        end
        chk("midrst_wr_pulses", 64'(wr_cnt - w0), 64'(3));

        // Fresh pass after reset
        run_pass(-1, exp_ramp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool2x2_engine.md
# pool2x2_engine

2x2/stride-2 signed max-pooling layer engine; the responder side of the layer start/done handshake driven by the CNN top-level sequencer. On a start pulse it reads an IN_DIM x IN_DIM feature map from the conv-output buffer through a synchronous read port. It writes the (IN_DIM/2)^2 pooled results to the pool-output buffer through a write port, then raises done. It sits between the conv engine's output RAM and the FC layer's input RAM.

## Interface
- DATA_W, 32, element width; signed two's complement
- IN_DIM, 6, input map side length; even (odd: trailing row/column ignored)
- ADDR_W, 6, read/write address width; must hold IN_DIM*IN_DIM-1
- OUT_DIM (localparam), IN_DIM/2, output side length
- Reset: rst is synchronous and active-high; clock is clk.
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin a pass; sampled in IDLE or DONE only
- busy  out  1  high while a pass is in progress
- done  out  1  level; high from pass completion until next accepted start or rst
- rd_en  out  1  read request to input buffer
- rd_addr  out  ADDR_W  input address, row-major (row*IN_DIM+col)
- rd_data  in  DATA_W  input data, valid exactly one cycle after rd_en
- wr_en  out  1  write strobe to output buffer, one cycle per result
- wr_addr  out  ADDR_W  output address, row-major (orow*OUT_DIM+ocol)
- wr_data  out  DATA_W  pooled max

## Operation
- States: IDLE, R0, R1, R2, R3, CMP, WR, DONE.
- IDLE/DONE + start -> R0; clear done, zero window counters (orow, ocol).
- R0..R3: rd_en=1. rd_addr = base, base+1, base+IN_DIM, base+IN_DIM+1, where base = 2*orow*IN_DIM + 2*ocol.
- Data capture: rd_data is sampled in R1, R2, R3 and CMP (one cycle after each read).
  - The first sample loads the running max unconditionally, so no zero floor applies and all-negative windows pool correctly.
  - Each later sample replaces the max only if it is strictly greater under signed comparison; ties keep the earlier value.
- CMP -> WR: final max registered into wr_data. In WR: wr_en=1, wr_addr = orow*OUT_DIM+ocol.
- WR -> R0 for the next window (ocol increments, wraps to 0 with orow increment), or -> DONE after window (OUT_DIM-1, OUT_DIM-1).
- DONE: done=1, busy=0; outputs hold until a new start.
- start in R0..WR is ignored; the pass is not restarted or extended.
- No arithmetic beyond comparison; wr_data is bit-exact copy of one input element.
- Reset (any state, incl. mid-pass): state IDLE, busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, counters 0. No further reads or writes; partial results in the output buffer are abandoned.

## Timing
- All outputs are registered. Cycle 0 = cycle in which start is sampled high.
- Window w (0..OUT_DIM^2-1):
  - rd_en in cycles 6w+1..6w+4
  - rd_data consumed in 6w+2..6w+5
  - wr_en in cycle 6w+6
- Two idle bus cycles per window (CMP and WR have no rd_en; R0..CMP have no wr_en).
- busy high cycles 1..6*OUT_DIM^2; done rises cycle 6*OUT_DIM^2+1.
- Default configuration: 9 windows, last write cycle 54, done at cycle 55.
- Restart from DONE: done falls and busy rises in the cycle after start is sampled.
- rst has priority over start in the same cycle.

## Test plan
- Ramp input mem[i]=i, i=0..35, start -> writes addr 0..8 = 7,9,11,19,21,23,31,33,35; done at cycle 55; exactly 9 wr_en pulses.
- All-negative mem[i]=-(i+1) -> writes -1,-3,-5,-13,-15,-17,-25,-27,-29; check that no result equals 0.
- Address/protocol check on ramp run:
  - window 4 reads addresses 14,15,20,21 in cycles 25..28
  - rd_en never asserted in CMP/WR
  - model returns rd_data one cycle late; any other latency assumption fails compare
- Ties and max in last slot: window 0 = {5,5,5,5} -> 5; window 1 = {0,0,0,0x7FFFFFFF} -> 0x7FFFFFFF; window 2 = {0x80000000,-1,-2,-3} -> -1.
- rst asserted at cycle 20 for one cycle -> from cycle 21 all outputs 0, no wr_en; new start completes normally with correct ramp results.
- start re-pulsed at cycle 10 (busy) -> ignored, done still at 55. start at cycle 60 (in DONE) -> done low at 61, second identical pass, done at 60+55.
